// File: rtl/store_pkg.sv
// Shared constants and types for the store unit: opcode, funct3 widths,
// byte-lane base masks and the sequencer state encoding.
package store_pkg;

  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [3:0] MASK_SB = 4'b0001;
  localparam logic [3:0] MASK_SH = 4'b0011;
  localparam logic [3:0] MASK_SW = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    FIN   = 2'd3
  } state_t;

  function automatic logic legal_f3(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// Request and memory-write bus of the store unit. The slave side is the unit
// itself; the master side is whoever issues stores and models memory.
interface store_unit_if;
  logic        StoreValid;
  logic        StoreReady;
  logic [6:0]  opCode;
  logic [2:0]  funct3;
  logic [31:0] ReadData1;
  logic [31:0] inExt;
  logic [31:0] ReadData2;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemWStrb;
  logic        MemWValid;
  logic        MemWReady;
  logic        StoreDone;
  logic        StoreErr;

  modport slave (
    input  StoreValid, opCode, funct3, ReadData1, inExt, ReadData2, MemWReady,
    output StoreReady, MemAddr, MemWData, MemWStrb, MemWValid, StoreDone, StoreErr
  );

  modport master (
    output StoreValid, opCode, funct3, ReadData1, inExt, ReadData2, MemWReady,
    input  StoreReady, MemAddr, MemWData, MemWStrb, MemWValid, StoreDone, StoreErr
  );
endinterface

// File: rtl/store_lane_align.sv
// Positions store data and byte enables across a two-word window so that a
// word-crossing store falls naturally into a low and a high beat.
module store_lane_align
  import store_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  output logic [63:0] o_shifted,
  output logic [7:0]  o_mask
);

  logic [3:0] w_base;

  always_comb begin
    w_base = 4'b0000;
    case (i_funct3)
      F3_SB:   w_base = MASK_SB;
      F3_SH:   w_base = MASK_SH;
      F3_SW:   w_base = MASK_SW;
      default: w_base = 4'b0000;
    endcase
    o_shifted = {32'b0, i_data} << {i_off, 3'b000};
    o_mask    = {4'b0000, w_base} << i_off;
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: turns an accepted store instruction into one or two registered
// byte-strobed write beats, then reports completion or error for one cycle.
module store_unit
  import store_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic         CLK,
  input  logic         RST_n,
  store_unit_if.slave  bus
);

  state_t      r_state;
  logic [31:0] r_hi_addr;
  logic [31:0] r_hi_data;
  logic [3:0]  r_hi_strb;

  logic [31:0] w_ea;
  logic [31:0] w_lo_addr;
  logic [63:0] w_shifted;
  logic [7:0]  w_mask;
  logic        w_accept;
  logic        w_bad;
  logic        w_beat_ack;

  assign w_ea       = bus.ReadData1 + bus.inExt;
  assign w_lo_addr  = {w_ea[31:2], 2'b00};
  assign w_accept   = bus.StoreValid && (r_state == IDLE) && (bus.opCode == OP_STORE);
  assign w_beat_ack = bus.MemWValid && bus.MemWReady;
  // A crossing store is only an error when splitting is disabled.
  assign w_bad      = !legal_f3(bus.funct3) || (!SPLIT_EN && (w_mask[7:4] != 4'b0000));

  assign bus.StoreReady = (r_state == IDLE);

  store_lane_align u_align (
    .i_funct3  (bus.funct3),
    .i_off     (w_ea[1:0]),
    .i_data    (bus.ReadData2),
    .o_shifted (w_shifted),
    .o_mask    (w_mask)
  );

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state       <= IDLE;
      bus.MemWValid <= 1'b0;
      bus.MemWStrb  <= 4'b0000;
      bus.MemAddr   <= 32'h0;
      bus.MemWData  <= 32'h0;
      bus.StoreDone <= 1'b0;
      bus.StoreErr  <= 1'b0;
    end else begin
      bus.StoreDone <= 1'b0;
      bus.StoreErr  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_bad) begin
              r_state      <= FIN;
              bus.StoreErr <= 1'b1;
            end else begin
              r_state       <= BEAT1;
              bus.MemWValid <= 1'b1;
              bus.MemAddr   <= w_lo_addr;
              bus.MemWData  <= w_shifted[31:0];
              bus.MemWStrb  <= w_mask[3:0];
              r_hi_addr     <= w_lo_addr + 32'd4;
              r_hi_data     <= w_shifted[63:32];
              r_hi_strb     <= w_mask[7:4];
            end
          end
        end
        BEAT1: begin
          if (w_beat_ack) begin
            if (r_hi_strb != 4'b0000) begin
              r_state      <= BEAT2;
              bus.MemAddr  <= r_hi_addr;
              bus.MemWData <= r_hi_data;
              bus.MemWStrb <= r_hi_strb;
            end else begin
              r_state       <= FIN;
              bus.MemWValid <= 1'b0;
              bus.StoreDone <= 1'b1;
            end
          end
        end
        BEAT2: begin
          if (w_beat_ack) begin
            r_state       <= FIN;
            bus.MemWValid <= 1'b0;
            bus.StoreDone <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
